// File: rtl/mem_bus_arbiter_pkg.sv
// Shared scalar types plus the arbiter's state and request types.
// The request struct is sized for the widest bus; narrower instances slice it.
package common;
    typedef logic        u1;
    typedef logic [63:0] u64;
endpackage

package pipes;
    import common::*;

    localparam int REQ_ADDR_W = 64;
    localparam int REQ_DATA_W = 64;
    localparam int REQ_STRB_W = REQ_DATA_W / 8;

    localparam logic [2:0] SIZE_WORD = 3'd2;

    typedef logic [REQ_STRB_W-1:0] strb_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_t;

    typedef struct packed {
        u1          write;
        u64         addr;
        logic [2:0] size;
        strb_t      strobe;
        u64         wdata;
    } mem_req_t;

    // Fetches are always word-sized reads, so the write fields are forced to zero.
    function automatic mem_req_t fetch_req(input u64 addr);
        mem_req_t r;
        r        = '0;
        r.write  = 1'b0;
        r.addr   = addr;
        r.size   = SIZE_WORD;
        r.strobe = '0;
        r.wdata  = '0;
        return r;
    endfunction

    function automatic mem_req_t data_req(input u1 write, input u64 addr,
                                          input logic [2:0] size, input strb_t strobe,
                                          input u64 wdata);
        mem_req_t r;
        r        = '0;
        r.write  = write;
        r.addr   = addr;
        r.size   = size;
        r.strobe = strobe;
        r.wdata  = wdata;
        return r;
    endfunction
endpackage

// File: rtl/mem_bus_arbiter_req_latch.sv
// Request register loaded at grant time; holds the transaction in flight stable.
module arb_req_latch
    import pipes::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     load,
    input  mem_req_t d,
    output mem_req_t q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter for a single-beat memory bus with alternating priority.
// Define ARB_PERF_EN to add grant and wait-cycle performance counters.
module mem_bus_arbiter
    import common::*;
    import pipes::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ok,
    output logic [DATA_W-1:0] i_data,

    input  logic              d_valid,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_size,
    input  logic [STRB_W-1:0] d_strobe,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ok,
    output logic [DATA_W-1:0] d_data,

    output logic              m_valid,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [2:0]        m_size,
    output logic [STRB_W-1:0] m_strobe,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_wait_cycles
`endif
);

    arb_state_t state;
    u1          last_d;
    u1          grant_d;
    u1          grant_i;
    u1          busy;
    mem_req_t   req_next;
    mem_req_t   req_q;

    // D wins ties unless it took the previous grant, which yields strict alternation.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            grant_d = d_valid && (!i_valid || !last_d);
            grant_i = i_valid && !grant_d;
        end
    end

    always_comb begin
        req_next = fetch_req(u64'(i_addr));
        if (grant_d) begin
            req_next = data_req(d_write, u64'(d_addr), d_size, strb_t'(d_strobe),
                                u64'(d_wdata));
        end
    end

    arb_req_latch u_req_latch (
        .clk   (clk),
        .reset (reset),
        .load  (grant_d | grant_i),
        .d     (req_next),
        .q     (req_q)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state  <= BUSY_D;
                        last_d <= 1'b1;
                    end else if (grant_i) begin
                        state  <= BUSY_I;
                        last_d <= 1'b0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (m_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus fields are zero while idle so a stale latched request never leaks out.
    always_comb begin
        busy     = (state != IDLE);
        m_valid  = busy;
        m_write  = busy & req_q.write;
        m_addr   = busy ? req_q.addr[ADDR_W-1:0] : '0;
        m_size   = busy ? req_q.size : 3'd0;
        m_strobe = busy ? req_q.strobe[STRB_W-1:0] : '0;
        m_wdata  = busy ? req_q.wdata[DATA_W-1:0] : '0;
    end

    always_comb begin
        i_ok   = (state == BUSY_I) && m_ready;
        d_ok   = (state == BUSY_D) && m_ready;
        i_data = i_ok ? m_rdata : '0;
        d_data = d_ok ? m_rdata : '0;
    end

`ifdef ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_i_grants    <= '0;
            perf_d_grants    <= '0;
            perf_wait_cycles <= '0;
        end else begin
            if (grant_i) begin
                perf_i_grants <= perf_i_grants + 32'd1;
            end
            if (grant_d) begin
                perf_d_grants <= perf_d_grants + 32'd1;
            end
            if (m_valid && !m_ready) begin
                perf_wait_cycles <= perf_wait_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; define ARB_PERF_EN to also check the counters.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic [63:0] i_addr;
    logic        i_ok;
    logic [63:0] i_data;
    logic        d_valid;
    logic        d_write;
    logic [63:0] d_addr;
    logic [2:0]  d_size;
    logic [7:0]  d_strobe;
    logic [63:0] d_wdata;
    logic        d_ok;
    logic [63:0] d_data;
    logic        m_valid;
    logic        m_write;
    logic [63:0] m_addr;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;
    logic [63:0] m_wdata;
    logic        m_ready;
    logic [63:0] m_rdata;
`ifdef ARB_PERF_EN
    logic [31:0] perf_i_grants;
    logic [31:0] perf_d_grants;
    logic [31:0] perf_wait_cycles;
`endif

    int checks;
    int errors;

    mem_bus_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (i_valid),
        .i_addr   (i_addr),
        .i_ok     (i_ok),
        .i_data   (i_data),
        .d_valid  (d_valid),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_size   (d_size),
        .d_strobe (d_strobe),
        .d_wdata  (d_wdata),
        .d_ok     (d_ok),
        .d_data   (d_data),
        .m_valid  (m_valid),
        .m_write  (m_write),
        .m_addr   (m_addr),
        .m_size   (m_size),
        .m_strobe (m_strobe),
        .m_wdata  (m_wdata),
        .m_ready  (m_ready),
        .m_rdata  (m_rdata)
`ifdef ARB_PERF_EN
        ,
        .perf_i_grants    (perf_i_grants),
        .perf_d_grants    (perf_d_grants),
        .perf_wait_cycles (perf_wait_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic applyStimulus(input logic iv, input logic [63:0] ia,
                                 input logic dv, input logic dw, input logic [63:0] da,
                                 input logic [2:0] ds, input logic [7:0] dst,
                                 input logic [63:0] dwd);
        i_valid  = iv;
        i_addr   = ia;
        d_valid  = dv;
        d_write  = dw;
        d_addr   = da;
        d_size   = ds;
        d_strobe = dst;
        d_wdata  = dwd;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One isolated transaction from a single requester, starting in an IDLE cycle.
    task automatic run_txn(input bit is_d, input logic [63:0] addr, input int waits,
                           input logic [63:0] rdata, input string tag);
        if (is_d) applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, addr, 3'd3, 8'hFF, 64'h0);
        else      applyStimulus(1'b1, addr, 1'b0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0);
        m_ready = 1'b0;
        next_cycle();
        for (int w = 0; w < waits; w++) begin
            settle();
            checkOutput({tag, "_wait_valid"}, 64'(m_valid), 64'h1);
            checkOutput({tag, "_wait_ok"}, 64'(is_d ? d_ok : i_ok), 64'h0);
            next_cycle();
        end
        m_ready = 1'b1;
        m_rdata = rdata;
        settle();
        checkOutput({tag, "_addr"}, m_addr, addr);
        checkOutput({tag, "_ok"}, 64'(is_d ? d_ok : i_ok), 64'h1);
        checkOutput({tag, "_data"}, is_d ? d_data : i_data, rdata);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0);
        next_cycle();
        m_ready = 1'b0;
        settle();
        checkOutput({tag, "_idle"}, 64'(m_valid), 64'h0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        m_ready = 1'b0;
        m_rdata = 64'h0;
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h10, 3'd3, 8'hFF, 64'h0);

        // Reset held two edges with a pending D request.
        next_cycle();
        settle();
        checkOutput("rst1_m_valid", 64'(m_valid), 64'h0);
        checkOutput("rst1_d_ok", 64'(d_ok), 64'h0);
        checkOutput("rst1_m_addr", m_addr, 64'h0);
        next_cycle();
        settle();
        checkOutput("rst2_m_valid", 64'(m_valid), 64'h0);
        checkOutput("rst2_d_data", d_data, 64'h0);
        reset = 1'b1;
        settle();
        checkOutput("rel_idle_m_valid", 64'(m_valid), 64'h0);
        next_cycle();
        settle();
        checkOutput("rel_issue_m_valid", 64'(m_valid), 64'h1);
        checkOutput("rel_issue_m_addr", m_addr, 64'h10);
        checkOutput("rel_issue_d_ok", 64'(d_ok), 64'h0);
        m_ready = 1'b1;
        m_rdata = 64'h55;
        settle();
        checkOutput("rel_d_ok", 64'(d_ok), 64'h1);
        checkOutput("rel_d_data", d_data, 64'h55);
        checkOutput("rel_i_ok", 64'(i_ok), 64'h0);
        d_valid = 1'b0;
        next_cycle();
        settle();
        checkOutput("rel_after_d_ok", 64'(d_ok), 64'h0);
        checkOutput("rel_after_m_valid", 64'(m_valid), 64'h0);

        // Lone fetch against zero-wait memory (m_ready stays high).
        m_rdata = 64'h13;
        applyStimulus(1'b1, 64'h8000_0000, 1'b0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0);
        settle();
        checkOutput("fetch_grant_m_valid", 64'(m_valid), 64'h0);
        checkOutput("fetch_grant_i_ok", 64'(i_ok), 64'h0);
        next_cycle();
        settle();
        checkOutput("fetch_m_valid", 64'(m_valid), 64'h1);
        checkOutput("fetch_m_addr", m_addr, 64'h8000_0000);
        checkOutput("fetch_m_write", 64'(m_write), 64'h0);
        checkOutput("fetch_m_size", 64'(m_size), 64'h2);
        checkOutput("fetch_m_strobe", 64'(m_strobe), 64'h0);
        checkOutput("fetch_i_ok", 64'(i_ok), 64'h1);
        checkOutput("fetch_i_data", i_data, 64'h13);
        checkOutput("fetch_d_ok", 64'(d_ok), 64'h0);
        i_valid = 1'b0;
        next_cycle();
        settle();
        checkOutput("fetch_after_i_ok", 64'(i_ok), 64'h0);

        // Both ports saturated: D first, then strict alternation.
        m_rdata = 64'hA5;
        applyStimulus(1'b1, 64'h20, 1'b1, 1'b0, 64'h10, 3'd3, 8'hFF, 64'h0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            settle();
            checkOutput("alt_m_valid", 64'(m_valid), 64'h1);
            checkOutput("alt_m_addr", m_addr, (k % 2 == 0) ? 64'h10 : 64'h20);
            checkOutput("alt_d_ok", 64'(d_ok), (k % 2 == 0) ? 64'h1 : 64'h0);
            checkOutput("alt_i_ok", 64'(i_ok), (k % 2 == 0) ? 64'h0 : 64'h1);
            next_cycle();
            settle();
            checkOutput("alt_turnaround", 64'(m_valid), 64'h0);
        end
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0);
        m_ready = 1'b0;

        // Store with four wait cycles; requester fields change after grant.
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'h100, 3'd2, 8'h0F, 64'hDEAD_BEEF);
        next_cycle();
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h200, 3'd3, 8'hF0, 64'h1234_5678);
        for (int w = 0; w < 4; w++) begin
            settle();
            checkOutput("st_m_valid", 64'(m_valid), 64'h1);
            checkOutput("st_m_write", 64'(m_write), 64'h1);
            checkOutput("st_m_addr", m_addr, 64'h100);
            checkOutput("st_m_size", 64'(m_size), 64'h2);
            checkOutput("st_m_strobe", 64'(m_strobe), 64'h0F);
            checkOutput("st_m_wdata", m_wdata, 64'hDEAD_BEEF);
            checkOutput("st_wait_d_ok", 64'(d_ok), 64'h0);
            next_cycle();
        end
        m_ready = 1'b1;
        m_rdata = 64'h77;
        settle();
        checkOutput("st_d_ok", 64'(d_ok), 64'h1);
        checkOutput("st_d_data", d_data, 64'h77);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0);
        next_cycle();
        m_ready = 1'b0;
        settle();
        checkOutput("st_single_pulse", 64'(d_ok), 64'h0);

        // Reset while BUSY_I waits; a late m_ready must be ignored.
        applyStimulus(1'b1, 64'h400, 1'b0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0);
        next_cycle();
        settle();
        checkOutput("mid_busy_m_valid", 64'(m_valid), 64'h1);
        checkOutput("mid_busy_m_addr", m_addr, 64'h400);
        reset = 1'b0;
        next_cycle();
        settle();
        checkOutput("mid_rst_m_valid", 64'(m_valid), 64'h0);
        checkOutput("mid_rst_i_ok", 64'(i_ok), 64'h0);
`ifdef ARB_PERF_EN
        checkOutput("perf_rst_i", 64'(perf_i_grants), 64'h0);
        checkOutput("perf_rst_wait", 64'(perf_wait_cycles), 64'h0);
`endif
        reset   = 1'b1;
        i_valid = 1'b0;
        m_ready = 1'b1;
        m_rdata = 64'h99;
        settle();
        checkOutput("late_ready_i_ok", 64'(i_ok), 64'h0);
        checkOutput("late_ready_i_data", i_data, 64'h0);
        next_cycle();
        settle();
        checkOutput("late_ready_m_valid", 64'(m_valid), 64'h0);
        checkOutput("late_ready_i_ok2", 64'(i_ok), 64'h0);
        m_ready = 1'b0;

        // Three D grants, two I grants, five wait cycles in total.
        run_txn(1'b1, 64'h1000, 2, 64'h1, "pd0");
        run_txn(1'b0, 64'h2000, 1, 64'h2, "pi0");
        run_txn(1'b1, 64'h1008, 0, 64'h3, "pd1");
        run_txn(1'b0, 64'h2008, 2, 64'h4, "pi1");
        run_txn(1'b1, 64'h1010, 0, 64'h5, "pd2");
`ifdef ARB_PERF_EN
        checkOutput("perf_d_grants", 64'(perf_d_grants), 64'h3);
        checkOutput("perf_i_grants", 64'(perf_i_grants), 64'h2);
        checkOutput("perf_wait_cycles", 64'(perf_wait_cycles), 64'h5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
